// File: rtl/piped_queue.sv
// piped_queue: first-word-fall-through queue. A distributed-RAM store
// feeds a registered head stage (dout), which can also step a bit field
// of the head entry in place. Total capacity is the RAM depth plus one.
module piped_queue #(
    parameter int WIDTH       = 33,
    parameter int DEPTH_LOG2  = 6,
    parameter int INC_LO      = 3,
    parameter int INC_HI      = 9,
    parameter int AFULL_LEVEL = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  inc_field,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CAP   = DEPTH + 1;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int FW    = INC_HI - INC_LO + 1;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0]         CNT_ONE = 1;
    localparam logic [FW-1:0]         FLD_ONE = 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] ra, wa;
    logic [CW-1:0]         rq_cnt;
    logic                  dout_full;

    logic rq_empty, rd, wr, ld, ram_we, ra_inc;

    assign rq_empty    = (rq_cnt == '0);
    assign count       = rq_cnt + {{(CW-1){1'b0}}, dout_full};
    assign empty       = ~dout_full;
    assign full        = (count == CW'(CAP));
    assign almost_full = (count >= CW'(AFULL_LEVEL));

    // A read frees a slot, so a write to a full queue is taken if it pairs with a read.
    assign rd = rd_en & dout_full;
    assign wr = wr_en & (~full | rd);

    // dout is reloaded on any pop that has a successor, or on a write into an
    // empty head. With an empty RAM the only possible source is din (bypass).
    assign ld     = (rd & (wr | ~rq_empty)) | (wr & ~dout_full);
    assign ram_we = wr & dout_full & ~(rd & rq_empty);
    assign ra_inc = rd & ~rq_empty;

    // Pointers, RAM occupancy, head-valid flag and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra        <= '0;
            wa        <= '0;
            rq_cnt    <= '0;
            dout_full <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ra_inc) ra <= ra + PTR_ONE;
            if (ram_we) wa <= wa + PTR_ONE;
            case ({ram_we, ra_inc})
                2'b10:   rq_cnt <= rq_cnt + CNT_ONE;
                2'b01:   rq_cnt <= rq_cnt - CNT_ONE;
                default: rq_cnt <= rq_cnt;
            endcase
            if (ld)      dout_full <= 1'b1;
            else if (rd) dout_full <= 1'b0;
            overflow  <= overflow  | (wr_en & ~wr);
            underflow <= underflow | (rd_en & ~dout_full);
        end
    end

    // Head register: load takes priority; otherwise optionally step the field.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (ld)
                dout <= rq_empty ? din : mem[ra];
            else if (inc_field)
                dout[INC_HI:INC_LO] <= dout[INC_HI:INC_LO] + FLD_ONE;
        end
    end

    // RAM write port; the read port is the asynchronous mem[ra] above.
    always_ff @(posedge clk) begin
        if (!rst && ram_we) mem[wa] <= din;
    end

endmodule
